tone_sequencer_multi: RTL and testbench

// Parametrised successor to the single-voice music processor: N_VOICES independent square-wave

---
 rtl/tone_sequencer_multi.sv | 155 +++++++++++++++
 tb/tb_tone_sequencer_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer_multi.sv
// tone_sequencer_multi: N independent square-wave voices, each fed from its own note FIFO.
// A shared millisecond prescaler times note durations for every voice.
module tone_sequencer_multi #(
  parameter int N_VOICES = 2,
  parameter int DEPTH    = 4,
  parameter int HP_W     = 16,
  parameter int DUR_W    = 12,
  parameter int TPM_W    = 16,
  localparam int VW      = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TPM_W-1:0]    ticks_per_milli,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [VW-1:0]       cmd_voice,
  input  logic [HP_W-1:0]     cmd_half_period,
  input  logic [DUR_W-1:0]    cmd_dur_ms,
  input  logic [N_VOICES-1:0] stop,
  output logic [N_VOICES-1:0] busy,
  output logic [N_VOICES-1:0] sound,
  output logic                sound_mix,
  output logic [7:0]          led
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_PLAY} vstate_e;

  logic [TPM_W-1:0]    pre_q, pre_d, pre_last;
  logic                ms_tick;
  logic [N_VOICES-1:0] sel, full;

  // A tpm of 0 behaves as 1; >= lets a lowered tpm wrap the count immediately.
  always_comb begin
    pre_last = (ticks_per_milli == '0) ? '0 : ticks_per_milli - TPM_W'(1);
    ms_tick  = (pre_q == pre_last);
    pre_d    = (pre_q >= pre_last) ? '0 : pre_q + TPM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  assign cmd_ready = |(sel & ~full & ~stop);
  assign sound_mix = ^sound;

  for (genvar i = 0; i < 8; i++) begin : g_led
    if (i < N_VOICES) begin : g_on
      assign led[i] = busy[i];
    end else begin : g_off
      assign led[i] = 1'b0;
    end
  end

  for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
    logic [HP_W+DUR_W-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_q, rd_q;
    logic                  empty, push, pop, load;
    logic [HP_W-1:0]       head_hp;
    logic [DUR_W-1:0]      head_dur;
    vstate_e               state_q, state_d;
    logic [HP_W-1:0]       hp_q, hp_d, hcnt_q, hcnt_d;
    logic [DUR_W-1:0]      dcnt_q, dcnt_d;
    logic                  snd_q, snd_d;

    assign sel[v]  = (cmd_voice == VW'(v));
    assign empty   = (wr_q == rd_q);
    assign full[v] = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push    = cmd_valid && sel[v] && !full[v] && !stop[v];
    assign {head_hp, head_dur} = mem_q[rd_q[AW-1:0]];
    assign busy[v]  = (state_q == S_PLAY) || !empty;
    assign sound[v] = snd_q;

    always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      hcnt_d  = hcnt_q;
      dcnt_d  = dcnt_q;
      snd_d   = snd_q;
      load    = 1'b0;
      pop     = 1'b0;
      case (state_q)
        S_IDLE: begin
          snd_d = 1'b0;
          if (!empty) load = 1'b1;
        end
        S_PLAY: begin
          if (hp_q == '0) begin
            snd_d = 1'b0;
          end else if (hcnt_q == hp_q - HP_W'(1)) begin
            hcnt_d = '0;
            snd_d  = ~snd_q;
          end else begin
            hcnt_d = hcnt_q + HP_W'(1);
          end
          if (ms_tick) begin
            if (dcnt_q <= DUR_W'(1)) begin
              if (!empty) begin
                load = 1'b1;
              end else begin
                state_d = S_IDLE;
                snd_d   = 1'b0;
              end
            end else begin
              dcnt_d = dcnt_q - DUR_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A zero-length note is popped and dropped, leaving the voice idle for that one cycle.
      if (load) begin
        pop     = 1'b1;
        hp_d    = head_hp;
        dcnt_d  = head_dur;
        hcnt_d  = '0;
        snd_d   = 1'b0;
        state_d = (head_dur == '0) ? S_IDLE : S_PLAY;
      end
      if (stop[v]) begin
        pop     = 1'b0;
        state_d = S_IDLE;
        snd_d   = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q    <= '0;
        rd_q    <= '0;
        state_q <= S_IDLE;
        hp_q    <= '0;
        hcnt_q  <= '0;
        dcnt_q  <= '0;
        snd_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hp_q    <= hp_d;
        hcnt_q  <= hcnt_d;
        dcnt_q  <= dcnt_d;
        snd_q   <= snd_d;
        if (push) wr_q <= wr_q + (AW+1)'(1);
        if (stop[v])  rd_q <= wr_q;
        else if (pop) rd_q <= rd_q + (AW+1)'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= {cmd_half_period, cmd_dur_ms};
    end
  end

endmodule

// File: tb/tb_tone_sequencer_multi.sv
// Bench for tone_sequencer_multi: note-queue model compared every cycle plus directed literal checks.
module tb_tone_sequencer_multi;
  localparam int NV = 3, DEPTH = 4, HP_W = 16, DUR_W = 12, TPM_W = 16, VW = 2, TPM = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [TPM_W-1:0]  tpm;
  logic              cmd_valid, cmd_ready;
  logic [VW-1:0]     cmd_voice;
  logic [HP_W-1:0]   cmd_hp;
  logic [DUR_W-1:0]  cmd_dur;
  logic [NV-1:0]     stop, busy, sound;
  logic              sound_mix;
  logic [7:0]        led;

  always #5 clk = ~clk;

  tone_sequencer_multi #(.N_VOICES(NV), .DEPTH(DEPTH), .HP_W(HP_W), .DUR_W(DUR_W), .TPM_W(TPM_W)) dut (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_voice(cmd_voice), .cmd_half_period(cmd_hp), .cmd_dur_ms(cmd_dur), .stop(stop),
    .busy(busy), .sound(sound), .sound_mix(sound_mix), .led(led)
  );

  int n_checks = 0, n_errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of pending notes per voice; a playing note's wave is (t / hp) mod 2.
  typedef struct packed { logic [HP_W-1:0] hp; logic [DUR_W-1:0] dur; } note_t;
  note_t       mq [NV][$];
  bit          m_act [NV];
  int unsigned m_hp [NV], m_t [NV], m_left [NV];
  int unsigned m_cyc;

  function automatic bit m_ready();
    if (int'(cmd_voice) >= NV) return 1'b0;
    return (mq[cmd_voice].size() < DEPTH) && !stop[cmd_voice];
  endfunction

  function automatic bit m_busy(input int v);
    return m_act[v] || (mq[v].size() > 0);
  endfunction

  function automatic bit m_sound(input int v);
    if (!m_act[v] || m_hp[v] == 0) return 1'b0;
    return ((m_t[v] / m_hp[v]) % 2) == 1;
  endfunction

  task automatic m_start(input int v);
    note_t n;
    n = mq[v].pop_front();
    if (n.dur == 0) m_act[v] = 1'b0;
    else begin
      m_act[v] = 1'b1; m_hp[v] = n.hp; m_t[v] = 0; m_left[v] = n.dur;
    end
  endtask

  always @(posedge clk) begin : model
    bit acc, tk;
    acc = cmd_valid && m_ready();
    if (rst) begin
      m_cyc = 0;
      for (int v = 0; v < NV; v++) begin mq[v].delete(); m_act[v] = 1'b0; end
    end else begin
      tk = (m_cyc % TPM) == TPM - 1;
      m_cyc++;
      for (int v = 0; v < NV; v++) begin
        if (stop[v]) begin
          mq[v].delete(); m_act[v] = 1'b0;
        end else if (!m_act[v]) begin
          if (mq[v].size() > 0) m_start(v);
        end else begin
          m_t[v]++;
          if (tk) begin
            m_left[v]--;
            if (m_left[v] == 0) begin
              if (mq[v].size() > 0) m_start(v);
              else m_act[v] = 1'b0;
            end
          end
        end
      end
      if (acc) mq[cmd_voice].push_back(note_t'{cmd_hp, cmd_dur});
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] el;
    logic       mix;
    if (chk_en) begin
      el = '0; mix = 1'b0;
      for (int v = 0; v < NV; v++) begin
        chk($sformatf("busy%0d", v), busy[v], m_busy(v));
        chk($sformatf("sound%0d", v), sound[v], m_sound(v));
        el[v] = m_busy(v);
        mix ^= m_sound(v);
      end
      chk("sound_mix", sound_mix, mix);
      chk("led", led, el);
      chk("cmd_ready", cmd_ready, m_ready());
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input int v, input int hp, input int dur, output bit acc);
    cmd_valid = 1'b1; cmd_voice = VW'(v); cmd_hp = HP_W'(hp); cmd_dur = DUR_W'(dur);
    #1 acc = cmd_ready;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int v, input int budget);
    int n = 0;
    while (busy[v] && n < budget) begin tick(); n++; end
    chk($sformatf("idle_timeout%0d", v), busy[v], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, r1, r2, drop, w;
    logic prev;
    rst = 1'b1; tpm = TPM; cmd_valid = 1'b0; cmd_voice = '0; cmd_hp = '0; cmd_dur = '0; stop = '0;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;

    // Reset mid-note
    push(0, 5, 50, acc);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    chk("t1_sound", sound, 0);
    chk("t1_busy", busy, 0);
    chk("t1_led", led, 0);
    chk("t1_ready", cmd_ready, 1);
    rst = 1'b0;

    // Single note timing: period 10, length 21..30 cycles
    push(0, 5, 3, acc);
    chk("t2_accept", acc, 1);
    chk("t2_busy_after_accept", busy[0], 1);
    n = 0; r1 = -1; r2 = -1; drop = -1; prev = sound[0];
    while (drop < 0 && n < 60) begin
      tick(); n++;
      if (!prev && sound[0]) begin
        if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
      end
      prev = sound[0];
      if (!busy[0]) drop = n;
    end
    chk("t2_first_rise", r1, 6);
    chk("t2_period", r2 - r1, 10);
    chk("t2_length", (drop - 1 >= 21) && (drop - 1 <= 30), 1);

    // Fill voice1 FIFO behind a long note
    push(1, 2, 20, acc);
    tick();
    push(1, 3, 1, acc); chk("t3_acc1", acc, 1);
    push(1, 4, 1, acc); chk("t3_acc2", acc, 1);
    push(1, 1, 2, acc); chk("t3_acc3", acc, 1);
    push(1, 2, 1, acc); chk("t3_acc4", acc, 1);
    cmd_valid = 1'b1; cmd_voice = 1; cmd_hp = 5; cmd_dur = 1;
    #1 chk("t3_full_ready", cmd_ready, 0);
    w = 0;
    while (!cmd_ready && w < 400) begin tick(); w++; end
    chk("t3_fifth_waited", (w > 0) && (w < 400), 1);
    tick();
    cmd_valid = 1'b0;
    wait_idle(1, 600);

    // Zero-length note then short note; then a rest
    push(0, 7, 0, acc);
    push(0, 3, 1, acc);
    n = 0;
    while (!sound[0] && n < 20) begin tick(); n++; end
    chk("t4_first_rise", n, 4);
    wait_idle(0, 100);
    push(0, 0, 2, acc);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_rest_sound", sound[0], 0);
      chk("t4_rest_busy", busy[0], 1);
    end
    wait_idle(0, 100);

    // Stop with queued notes and a simultaneous push
    push(0, 3, 30, acc);
    push(0, 2, 5, acc);
    push(0, 2, 5, acc);
    push(0, 2, 5, acc);
    stop = 3'b001; cmd_valid = 1'b1; cmd_voice = 0; cmd_hp = 1; cmd_dur = 1;
    #1 chk("t5_ready_stop", cmd_ready, 0);
    tick();
    stop = '0; cmd_valid = 1'b0;
    chk("t5_busy", busy[0], 0);
    chk("t5_sound", sound[0], 0);
    #1 chk("t5_ready_after", cmd_ready, 1);

    // Several voices at once; invalid voice index
    push(0, 4, 5, acc);
    push(1, 6, 5, acc);
    push(2, 1, 1, acc);
    chk("t6_led2", led[2], 1);
    repeat (30) tick();
    cmd_valid = 1'b1; cmd_voice = 3; cmd_hp = 2; cmd_dur = 2;
    #1 chk("t6_bad_voice_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    for (int v = 0; v < NV; v++) wait_idle(v, 200);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
